// File: rtl/flappy_engine_if.sv
// Game-engine bus: per-frame control pulses in, bird/pipe/score state out.
interface flappy_engine_if #(
  parameter int NUM_PIPES = 3
);
  logic                     frame_tick;
  logic                     flap;
  logic                     start;
  logic [1:0]               state;
  logic [9:0]               bird_y;
  logic [11*NUM_PIPES-1:0]  pipe_x;
  logic [10*NUM_PIPES-1:0]  gap_y;
  logic                     hit;
  logic [15:0]              score;

  modport master (
    output frame_tick, flap, start,
    input  state, bird_y, pipe_x, gap_y, hit, score
  );

  modport slave (
    input  frame_tick, flap, start,
    output state, bird_y, pipe_x, gap_y, hit, score
  );
endinterface

// File: rtl/flappy_engine.sv
// Flappy-bird game state: IDLE/PLAY/DEAD FSM, bird physics, NUM_PIPES movers, collision, BCD score.
// Motion advances once per frame_tick; state transitions take 1 cycle; no backpressure.
module flappy_engine #(
  parameter int NUM_PIPES    = 3,
  parameter int SCREEN_W     = 640,
  parameter int GROUND_Y     = 440,
  parameter int BIRD_X       = 100,
  parameter int BIRD_SIZE    = 16,
  parameter int BIRD_Y0      = 200,
  parameter int PIPE_W       = 40,
  parameter int PIPE_SPACING = 240,
  parameter int PIPE_SPEED   = 2,
  parameter int GAP_H        = 120,
  parameter int GAP_MIN      = 60,
  parameter int GAP_MASK     = 255,
  parameter int GRAVITY      = 1,
  parameter int FLAP_V       = 8,
  parameter int MAX_FALL     = 8
) (
  input logic              clk,
  input logic              reset,
  flappy_engine_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam logic [10:0]        SPEED    = 11'(PIPE_SPEED);
  localparam logic [10:0]        WRAP_ADD = 11'(NUM_PIPES * PIPE_SPACING - PIPE_SPEED);
  localparam logic [9:0]         Y_MAX    = 10'(GROUND_Y - BIRD_SIZE);
  localparam logic [9:0]         Y_INIT   = 10'(BIRD_Y0);
  localparam logic [9:0]         GAP_BASE = 10'(GAP_MIN);
  localparam logic [7:0]         GMASK    = 8'(GAP_MASK);
  localparam logic signed [7:0]  V_FLAP   = 8'(-FLAP_V);
  localparam logic signed [7:0]  V_G      = 8'(GRAVITY);
  localparam logic signed [7:0]  V_MAX    = 8'(MAX_FALL);
  localparam logic [11:0]        X_LO     = 12'(BIRD_X);
  localparam logic [11:0]        X_HI     = 12'(BIRD_X + BIRD_SIZE);
  localparam logic [11:0]        PW       = 12'(PIPE_W);
  localparam logic [10:0]        BSZ      = 11'(BIRD_SIZE);
  localparam logic [10:0]        GH       = 11'(GAP_H);

  state_t             state_q, state_d;
  logic [9:0]         bird_q, bird_d;
  logic signed [7:0]  vel_q, vel_d;
  logic [10:0]        px_q [NUM_PIPES];
  logic [10:0]        px_d [NUM_PIPES];
  logic [9:0]         gap_q [NUM_PIPES];
  logic [9:0]         gap_d [NUM_PIPES];
  logic [15:0]        score_q, score_d;
  logic               latch_q, latch_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               hit_c;

  // Candidate next-frame values, applied only on a non-fatal tick in PLAY
  logic signed [7:0]  vel_inc, vel_mv;
  logic signed [11:0] y_sum;
  logic [9:0]         bird_mv;
  logic [10:0]        px_mv [NUM_PIPES];
  logic [9:0]         gap_mv [NUM_PIPES];
  logic [15:0]        score_mv;
  logic               do_init;

  function automatic logic [10:0] init_px(input int idx);
    return 11'(SCREEN_W + idx * PIPE_SPACING);
  endfunction

  // Saturating 4-digit BCD increment
  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = 1'b1;
    if (s == 16'h9999) return s;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    hit_c = (bird_q == Y_MAX);
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (({1'b0, px_q[i]} < X_HI) && ({1'b0, px_q[i]} + PW > X_LO)) begin
        if (!((bird_q >= gap_q[i]) &&
              ({1'b0, bird_q} + BSZ <= {1'b0, gap_q[i]} + GH))) begin
          hit_c = 1'b1;
        end
      end
    end
  end

  always_comb begin
    vel_inc = vel_q + V_G;
    if (latch_q || bus.flap) vel_mv = V_FLAP;
    else if (vel_inc > V_MAX) vel_mv = V_MAX;
    else vel_mv = vel_inc;

    y_sum = $signed({2'b00, bird_q}) + $signed({{4{vel_mv[7]}}, vel_mv});
    if (y_sum < 12'sd0) bird_mv = 10'd0;
    else if (y_sum > $signed({2'b00, Y_MAX})) bird_mv = Y_MAX;
    else bird_mv = y_sum[9:0];

    score_mv = score_q;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (px_q[i] < SPEED) begin
        px_mv[i]  = px_q[i] + WRAP_ADD;
        gap_mv[i] = GAP_BASE + {2'b00, lfsr_q[7:0] & GMASK};
      end else begin
        px_mv[i]  = px_q[i] - SPEED;
        gap_mv[i] = gap_q[i];
      end
      if (({1'b0, px_q[i]} + PW >= X_LO) && ({1'b0, px_mv[i]} + PW < X_LO)) begin
        score_mv = bcd_inc(score_mv);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bird_d  = bird_q;
    vel_d   = vel_q;
    px_d    = px_q;
    gap_d   = gap_q;
    score_d = score_q;
    latch_d = latch_q;
    do_init = 1'b0;
    lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    case (state_q)
      IDLE: begin
        if (bus.start || bus.flap) begin
          state_d = PLAY;
          latch_d = 1'b0;
        end
      end
      PLAY: begin
        if (bus.frame_tick) begin
          latch_d = 1'b0;
          if (hit_c) begin
            state_d = DEAD;
          end else begin
            vel_d   = vel_mv;
            bird_d  = bird_mv;
            px_d    = px_mv;
            gap_d   = gap_mv;
            score_d = score_mv;
          end
        end else if (bus.flap) begin
          latch_d = 1'b1;
        end
      end
      DEAD: begin
        if (bus.start) begin
          state_d = IDLE;
          do_init = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_init) begin
      bird_d  = Y_INIT;
      vel_d   = 8'sd0;
      score_d = 16'h0000;
      latch_d = 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        px_d[i]  = init_px(i);
        gap_d[i] = GAP_BASE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bird_q  <= Y_INIT;
      vel_q   <= 8'sd0;
      score_q <= 16'h0000;
      latch_q <= 1'b0;
      lfsr_q  <= 16'hACE1;
      for (int i = 0; i < NUM_PIPES; i++) begin
        px_q[i]  <= init_px(i);
        gap_q[i] <= GAP_BASE;
      end
    end else begin
      state_q <= state_d;
      bird_q  <= bird_d;
      vel_q   <= vel_d;
      score_q <= score_d;
      latch_q <= latch_d;
      lfsr_q  <= lfsr_d;
      px_q    <= px_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.state  = state_q;
  assign bus.bird_y = bird_q;
  assign bus.hit    = hit_c;
  assign bus.score  = score_q;

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
    assign bus.pipe_x[11*g +: 11] = px_q[g];
    assign bus.gap_y[10*g +: 10]  = gap_q[g];
  end

endmodule
